// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: CDC sync, per-bit debounce, edge pulses, sticky maskable irq.
// Latency: pin to gpio_r / edge pulse is CDC+cfg_len+1 cycles; no backpressure, outputs always valid.
module gpio_in_filter #(
  parameter int GW  = 32,
  parameter int CDC = 2,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [GW-1:0] gpio_i,
  input  logic [CW-1:0] cfg_len,
  input  logic [GW-1:0] irq_ena_rise,
  input  logic [GW-1:0] irq_ena_fall,
  input  logic [GW-1:0] irq_clr,
  output logic [GW-1:0] gpio_r,
  output logic [GW-1:0] gpio_rise,
  output logic [GW-1:0] gpio_fall,
  output logic [GW-1:0] irq_pnd,
  output logic          irq
);

  logic [GW-1:0] r_sync [CDC];
  logic [CW-1:0] r_cnt  [GW];
  logic [GW-1:0] r_lvl;
  logic [GW-1:0] r_rise;
  logic [GW-1:0] r_fall;
  logic [GW-1:0] r_pnd;
  logic          r_irq;

  logic [GW-1:0] w_sync;
  logic [GW-1:0] w_diff;
  logic [GW-1:0] w_acc;
  logic [GW-1:0] w_set;
  logic [GW-1:0] w_pnd_nxt;

  assign w_sync = r_sync[CDC-1];
  assign w_diff = w_sync ^ r_lvl;

  // >= lets a lowered window take effect on the very next mismatching cycle
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < GW; i++) begin
      w_acc[i] = w_diff[i] && (r_cnt[i] >= cfg_len);
    end
  end

  assign w_set     = (r_rise & irq_ena_rise) | (r_fall & irq_ena_fall);
  assign w_pnd_nxt = w_set | (r_pnd & ~irq_clr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < CDC; k++) begin
        r_sync[k] <= '0;
      end
      for (int i = 0; i < GW; i++) begin
        r_cnt[i] <= '0;
      end
      r_lvl  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_pnd  <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int k = 1; k < CDC; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      for (int i = 0; i < GW; i++) begin
        if (!w_diff[i] || w_acc[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
      r_lvl  <= r_lvl ^ w_acc;
      r_rise <= w_acc & w_sync;
      r_fall <= w_acc & ~w_sync;
      r_pnd  <= w_pnd_nxt;
      r_irq  <= |w_pnd_nxt;
    end
  end

  assign gpio_r    = r_lvl;
  assign gpio_rise = r_rise;
  assign gpio_fall = r_fall;
  assign irq_pnd   = r_pnd;
  assign irq       = r_irq;

endmodule
